// File: rtl/anubis_pkg.sv
// Shared constants and FSM encoding for the Anubis-128 round scheduler.
package anubis_pkg;

  localparam int NR_DEFAULT = 12;
  localparam int W          = 128;
  localparam int ROUND_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Index of the last round; the counter is ROUND_W bits so NR must not exceed 16.
  function automatic logic [ROUND_W-1:0] last_round(input int nr);
    return ROUND_W'(nr - 1);
  endfunction

endpackage

// File: rtl/anubis_core_sched_rr_arbiter2.sv
// Two-input round-robin grant; ptr names the requester that wins a tie.
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/anubis_core_sched.sv
// Two-requester scheduler around a combinational Anubis-128 round datapath:
// owns the master keys, the working state/key registers and the round counter.
module anubis_core_sched #(
  parameter int NR = anubis_pkg::NR_DEFAULT,
  parameter int W  = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key0_wr,
  input  logic [W-1:0] key0_data,
  input  logic         key1_wr,
  input  logic [W-1:0] key1_data,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  output logic         res0_valid,
  input  logic         res0_ready,
  output logic         res1_valid,
  input  logic         res1_ready,
  output logic [W-1:0] res_data,
  output logic [W-1:0] dp_state,
  output logic [W-1:0] dp_key,
  output logic [3:0]   dp_round,
  output logic         dp_first,
  output logic         dp_last,
  input  logic [W-1:0] dp_state_nxt,
  input  logic [W-1:0] dp_key_nxt,
  output logic         busy,
  output logic         owner
);

  import anubis_pkg::*;

  localparam logic [ROUND_W-1:0] ROUND_LAST = last_round(NR);

  sched_state_e       state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               owner_q, owner_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [W-1:0]       dp_state_q, dp_state_d;
  logic [W-1:0]       dp_key_q, dp_key_d;
  logic [W-1:0]       res_data_q, res_data_d;
  logic [W-1:0]       key0_q, key1_q;
  logic [1:0]         key_vld_q;

  logic [1:0]         eligible;
  logic [1:0]         gnt;

  assign eligible = {req1_valid & key_vld_q[1], req0_valid & key_vld_q[0]};

  rr_arbiter2 u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .gnt      (gnt)
  );

  // Master keys are only sampled at grant, so a write mid-block affects the next block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key0_q    <= '0;
      key1_q    <= '0;
      key_vld_q <= 2'b00;
    end else begin
      if (key0_wr) begin
        key0_q       <= key0_data;
        key_vld_q[0] <= 1'b1;
      end
      if (key1_wr) begin
        key1_q       <= key1_data;
        key_vld_q[1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      round_q    <= '0;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      dp_state_q <= '0;
      dp_key_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      dp_state_q <= dp_state_d;
      dp_key_q   <= dp_key_d;
      res_data_q <= res_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    dp_state_d = dp_state_q;
    dp_key_d   = dp_key_q;
    res_data_d = res_data_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res0_valid = 1'b0;
    res1_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        if (gnt != 2'b00) begin
          state_d    = RUN;
          round_d    = '0;
          owner_d    = gnt[1];
          dp_state_d = gnt[1] ? req1_data : req0_data;
          dp_key_d   = gnt[1] ? key1_q : key0_q;
        end
      end

      RUN: begin
        dp_state_d = dp_state_nxt;
        dp_key_d   = dp_key_nxt;
        if (round_q == ROUND_LAST) begin
          res_data_d = dp_state_nxt;
          round_d    = '0;
          state_d    = DONE;
        end else begin
          round_d = round_q + 1'b1;
        end
      end

      DONE: begin
        res0_valid = ~owner_q;
        res1_valid = owner_q;
        if (owner_q ? res1_ready : res0_ready) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Round flags are qualified with RUN so idle/reset outputs stay all-zero.
  assign dp_state = dp_state_q;
  assign dp_key   = dp_key_q;
  assign dp_round = round_q;
  assign dp_first = (state_q == RUN) && (round_q == '0);
  assign dp_last  = (state_q == RUN) && (round_q == ROUND_LAST);
  assign res_data = res_data_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;

endmodule
